regfile_mp_sb: RTL and testbench

Parametrised multi-port register file with an integrated busy-bit scoreboard, the next generation of the CPU's two-read/one-write `registerfile`. It provides `NUM_READ_PORTS` asynchronous read ports, one write (writeback) port, a hardwired-zero register 0, and per-register busy tracking so decode can tell whether each operand is ready. It sits between decode/issue and writeback in the RISC-V core.

---
 rtl/regfile_mp_sb_pkg.sv | 20 ++
 rtl/regfile_mp_sb_if.sv | 40 ++++
 rtl/regfile_mp_sb_scoreboard.sv | 60 ++++++
 rtl/regfile_mp_sb.sv | 79 +++++++
 tb/tb_regfile_mp_sb.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and helpers for the multi-port register file
//               with busy-bit scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_NUM_REGISTERS = 32;
  localparam int MAX_READ_PORTS        = 4;

  // Address width for a register file of n entries (at least one bit).
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_mp_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb_if
// Description : Read/writeback/issue bundle between decode/issue, writeback
//               and the register file. The master drives addresses and
//               commands; the slave (register file) returns data and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGISTERS  = DEFAULT_NUM_REGISTERS,
  parameter int NUM_READ_PORTS = 2
);
  localparam int AW = addr_width(NUM_REGISTERS);

  logic [NUM_READ_PORTS-1:0][AW-1:0]         reg_rd;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] data_out;
  logic [NUM_READ_PORTS-1:0]                 rd_ready;
  logic                                      write;
  logic [AW-1:0]                             reg_wr;
  logic [DATA_WIDTH-1:0]                     data_in;
  logic                                      issue;
  logic [AW-1:0]                             issue_rd;
  logic                                      flush;
  logic                                      busy_any;

  modport master (
    output reg_rd, write, reg_wr, data_in, issue, issue_rd, flush,
    input  data_out, rd_ready, busy_any
  );

  modport slave (
    input  reg_rd, write, reg_wr, data_in, issue, issue_rd, flush,
    output data_out, rd_ready, busy_any
  );

endinterface : regfile_mp_sb_if
`default_nettype wire

// File: rtl/regfile_mp_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits. Priority each edge: flush clears
//               everything, then an issue sets its destination (the newest
//               producer wins over a same-cycle writeback), then a writeback
//               clears its destination. Register 0 is never busy.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
  parameter int AW            = addr_width(NUM_REGISTERS)
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     write,
  input  wire logic [AW-1:0]            reg_wr,
  input  wire logic                     issue,
  input  wire logic [AW-1:0]            issue_rd,
  input  wire logic                     flush,
  output logic      [NUM_REGISTERS-1:0] busy,
  output logic                          busy_any
);

  logic [NUM_REGISTERS-1:0] r_busy;
  logic [NUM_REGISTERS-1:0] w_busy_nxt;
  logic                     r_busy_any;

  // Next-state busy vector: clear on writeback first so a same-cycle issue overrides it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (write)
        w_busy_nxt[reg_wr] = 1'b0;
      if (issue)
        w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy vector and its registered OR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_any <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_any <= |w_busy_nxt;
    end
  end

  assign busy     = r_busy;
  assign busy_any = r_busy_any;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : Multi-port register file with hardwired-zero register 0,
//               one writeback port, NUM_READ_PORTS combinational read ports
//               and a busy-bit scoreboard reporting operand readiness.
//               Define REGFILE_BYPASS_EN to forward same-cycle writeback data
//               (and readiness) to matching read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGISTERS  = DEFAULT_NUM_REGISTERS,
  parameter int NUM_READ_PORTS = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  regfile_mp_sb_if.slave bus
);

  localparam int AW = addr_width(NUM_REGISTERS);

  logic [DATA_WIDTH-1:0]    r_regs [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] w_busy;

  // Writeback into the data array; register 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGISTERS; i++)
        r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGISTERS; i++)
        if (bus.write && (bus.reg_wr == AW'(i)))
          r_regs[i] <= bus.data_in;
    end
  end

  regfile_scoreboard #(
    .NUM_REGISTERS (NUM_REGISTERS),
    .AW            (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .write    (bus.write),
    .reg_wr   (bus.reg_wr),
    .issue    (bus.issue),
    .issue_rd (bus.issue_rd),
    .flush    (bus.flush),
    .busy     (w_busy),
    .busy_any (bus.busy_any)
  );

  // Read muxes: each port resolves zero-register, bypass and readiness on its own.
  always_comb begin
    bus.data_out = '0;
    bus.rd_ready = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if (bus.reg_rd[p] == '0) begin
        bus.data_out[p] = '0;
        bus.rd_ready[p] = 1'b1;
      end else begin
        bus.data_out[p] = r_regs[bus.reg_rd[p]];
        bus.rd_ready[p] = ~w_busy[bus.reg_rd[p]];
`ifdef REGFILE_BYPASS_EN
        if (bus.write && (bus.reg_wr == bus.reg_rd[p])) begin
          bus.data_out[p] = bus.data_in;
          bus.rd_ready[p] = 1'b1;
        end
`else
        // Without forwarding, data and readiness follow stored state only.
`endif
      end
    end
  end

endmodule : regfile_mp_sb
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp_sb
// Description : Directed self-checking bench for regfile_mp_sb. Expectations
//               follow REGFILE_BYPASS_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_mp_sb_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_READ_PORTS(NP)) bus ();

  regfile_mp_sb #(
    .DATA_WIDTH     (DW),
    .NUM_REGISTERS  (NR),
    .NUM_READ_PORTS (NP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write    = 1'b0;
    bus.issue    = 1'b0;
    bus.flush    = 1'b0;
    bus.reg_wr   = '0;
    bus.issue_rd = '0;
    bus.data_in  = '0;
  endtask

  initial begin
    idle();
    bus.reg_rd[0] = 5'd1;
    bus.reg_rd[1] = 5'd2;
    #3;
    check("rst_data0", bus.data_out[0], 32'h0);
    check("rst_ready", {30'd0, bus.rd_ready}, 32'h3);
    check("rst_busy_any", {31'd0, bus.busy_any}, 32'h0);
    step();
    rst = 1'b0;

    // Writes to x1, x2 and read back
    bus.write = 1'b1; bus.reg_wr = 5'd1; bus.data_in = 32'hDEADBEEF;
    step();
    bus.reg_wr = 5'd2; bus.data_in = 32'h12345678;
    step();
    idle();
    #1;
    check("x1_data", bus.data_out[0], 32'hDEADBEEF);
    check("x2_data", bus.data_out[1], 32'h12345678);
    check("x1x2_ready", {30'd0, bus.rd_ready}, 32'h3);

    // x0 ignores writes and issues
    bus.write = 1'b1; bus.reg_wr = 5'd0; bus.data_in = 32'hFFFFFFFF;
    bus.issue = 1'b1; bus.issue_rd = 5'd0;
    step();
    idle();
    bus.reg_rd[0] = 5'd0;
    #1;
    check("x0_data", bus.data_out[0], 32'h0);
    check("x0_ready", {31'd0, bus.rd_ready[0]}, 32'h1);
    check("x0_busy_any", {31'd0, bus.busy_any}, 32'h0);

    // Issue x5, then writeback x5
    bus.issue = 1'b1; bus.issue_rd = 5'd5;
    step();
    idle();
    bus.reg_rd[0] = 5'd5;
    #1;
    check("x5_busy_ready", {31'd0, bus.rd_ready[0]}, 32'h0);
    check("x5_busy_any", {31'd0, bus.busy_any}, 32'h1);
    bus.write = 1'b1; bus.reg_wr = 5'd5; bus.data_in = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x5_byp_ready", {31'd0, bus.rd_ready[0]}, 32'h1);
    check("x5_byp_data", bus.data_out[0], 32'hA5A5A5A5);
`else
    check("x5_nobyp_ready", {31'd0, bus.rd_ready[0]}, 32'h0);
    check("x5_nobyp_data", bus.data_out[0], 32'h0);
`endif
    check("x5_other_port", bus.data_out[1], 32'h12345678);
    step();
    idle();
    #1;
    check("x5_ready_after", {31'd0, bus.rd_ready[0]}, 32'h1);
    check("x5_data_after", bus.data_out[0], 32'hA5A5A5A5);
    check("x5_busy_any_clr", {31'd0, bus.busy_any}, 32'h0);

    // Same-cycle issue and write of a busy x7: stays busy, data updated
    bus.issue = 1'b1; bus.issue_rd = 5'd7;
    step();
    bus.write = 1'b1; bus.reg_wr = 5'd7; bus.data_in = 32'h77770007;
    bus.reg_rd[1] = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x7_byp_ready", {31'd0, bus.rd_ready[1]}, 32'h1);
    check("x7_byp_data", bus.data_out[1], 32'h77770007);
`else
    check("x7_nobyp_ready", {31'd0, bus.rd_ready[1]}, 32'h0);
    check("x7_nobyp_data", bus.data_out[1], 32'h0);
`endif
    step();
    idle();
    #1;
    check("x7_still_busy", {31'd0, bus.rd_ready[1]}, 32'h0);
    check("x7_data", bus.data_out[1], 32'h77770007);
    check("x7_busy_any", {31'd0, bus.busy_any}, 32'h1);

    // Issue x3, x4, x6; flush with simultaneous issue x8 and write x9
    bus.issue = 1'b1; bus.issue_rd = 5'd3; step();
    bus.issue_rd = 5'd4; step();
    bus.issue_rd = 5'd6; step();
    idle();
    bus.reg_rd[0] = 5'd3; bus.reg_rd[1] = 5'd4;
    #1;
    check("x3x4_busy", {30'd0, bus.rd_ready}, 32'h0);
    bus.flush = 1'b1; bus.issue = 1'b1; bus.issue_rd = 5'd8;
    bus.write = 1'b1; bus.reg_wr = 5'd9; bus.data_in = 32'h0000C0DE;
    step();
    idle();
    bus.reg_rd[0] = 5'd6; bus.reg_rd[1] = 5'd8;
    #1;
    check("flush_ready_x6x8", {30'd0, bus.rd_ready}, 32'h3);
    check("flush_busy_any", {31'd0, bus.busy_any}, 32'h0);
    bus.reg_rd[0] = 5'd7; bus.reg_rd[1] = 5'd9;
    #1;
    check("flush_ready_x7x9", {30'd0, bus.rd_ready}, 32'h3);
    check("flush_write_x9", bus.data_out[1], 32'h0000C0DE);

    // Asynchronous reset between edges
    bus.issue = 1'b1; bus.issue_rd = 5'd2;
    step();
    idle();
    bus.reg_rd[0] = 5'd1; bus.reg_rd[1] = 5'd2;
    #1;
    check("pre_rst_ready", {30'd0, bus.rd_ready}, 32'h1);
    check("pre_rst_data", bus.data_out[0], 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("arst_data0", bus.data_out[0], 32'h0);
    check("arst_data1", bus.data_out[1], 32'h0);
    check("arst_ready", {30'd0, bus.rd_ready}, 32'h3);
    check("arst_busy_any", {31'd0, bus.busy_any}, 32'h0);
    step();
    rst = 1'b0;
    bus.write = 1'b1; bus.reg_wr = 5'd1; bus.data_in = 32'h13579BDF;
    step();
    idle();
    #1;
    check("post_rst_write", bus.data_out[0], 32'h13579BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_mp_sb
`default_nettype wire
